serial_full_subtractor: RTL and testbench



---
 rtl/serial_full_subtractor.sv | 134 +++++++++++++
 tb/tb_serial_full_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_full_subtractor
// Purpose  : Bit-serial, LSB-first subtractor computing a_in - b_in - bin over
//            WIDTH bits with a single full-subtractor cell and a borrow
//            flip-flop. Operands load in parallel on an accepted start, one
//            bit is processed per clock, and the parallel difference and
//            borrow-out are presented with a one-cycle done pulse.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous, active-high reset
//            start      - load request, honoured only while ready=1
//            a_in       - minuend   (WIDTH bits)
//            b_in       - subtrahend (WIDTH bits)
//            bin        - borrow-in
//            ready      - idle or done; a start will be accepted
//            busy       - shifting in progress
//            dbit       - serial difference bit of the current cycle
//            dbit_valid - qualifies dbit (high only while shifting)
//            diff       - final difference, updated on completion only
//            bout       - final borrow-out, updated on completion only
//            done       - one-cycle pulse, diff/bout newly valid
// Revision : 1.0 - initial release
// ============================================================================
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             dbit,
    output logic             dbit_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);

    // Counter must be able to hold WIDTH itself (value after the last shift).
    localparam int c_CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_a0;
    logic               w_b0;
    logic               w_d;
    logic               w_borrow_next;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_shift;

    // Full-subtractor cell on the LSBs of the operand shift registers.
    assign w_a0          = r_a[0];
    assign w_b0          = r_b[0];
    assign w_d           = w_a0 ^ w_b0 ^ r_borrow;
    assign w_borrow_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_borrow);
    assign w_shift       = (r_state == c_SHIFT);

    // New difference bit enters from the MSB side so that after WIDTH
    // shifts the first (LSB) bit has arrived at position 0.
    always_comb begin
        w_res_next            = r_res >> 1;
        w_res_next[WIDTH-1]   = w_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                c_SHIFT: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_borrow <= w_borrow_next;
                    r_res    <= w_res_next;
                    r_cnt    <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST) begin
                        // Publish straight from the next-state values so the
                        // result lands on the final shift edge itself.
                        r_diff  <= w_res_next;
                        r_bout  <= w_borrow_next;
                        r_state <= c_DONE;
                    end
                end
                // IDLE and DONE both accept a new operation; any illegal
                // encoding recovers the same way.
                default: begin
                    if (start) begin
                        r_a      <= a_in;
                        r_b      <= b_in;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_state  <= c_SHIFT;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready      = (r_state == c_IDLE) || (r_state == c_DONE);
    assign busy       = w_shift;
    assign done       = (r_state == c_DONE);
    assign dbit_valid = w_shift;
    assign dbit       = w_shift & w_d;
    assign diff       = r_diff;
    assign bout       = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_full_subtractor
// Purpose  : Directed self-checking bench for serial_full_subtractor, using a
//            1-bit and an 8-bit instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_full_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // WIDTH=1 instance
    logic start1, a1, b1, bin1;
    logic ready1, busy1, dbit1, dv1, diff1, bout1, done1;

    // WIDTH=8 instance
    logic       start8, bin8;
    logic [7:0] a8, b8;
    logic       ready8, busy8, dbit8, dv8, bout8, done8;
    logic [7:0] diff8;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;
    int          nd;
    logic [31:0] dbits;
    logic        held;
    logic [7:0]  d0;
    logic [1:0]  exp_tt [8];

    serial_full_subtractor #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a_in(a1), .b_in(b1), .bin(bin1),
        .ready(ready1), .busy(busy1), .dbit(dbit1), .dbit_valid(dv1),
        .diff(diff1), .bout(bout1), .done(done1)
    );

    serial_full_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8),
        .a_in(a8), .b_in(b8), .bin(bin8),
        .ready(ready8), .busy(busy8), .dbit(dbit8), .dbit_valid(dv8),
        .diff(diff8), .bout(bout8), .done(done8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive operands with start for exactly the accepting edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; bin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Runs until done8, collecting serial bits and checking diff stability.
    task automatic wait_done8();
        cyc = 0; nd = 0; dbits = '0; held = 1'b1; d0 = diff8;
        while (!done8 && cyc < 40) begin
            if (dv8 && nd < 32) begin
                dbits[nd] = dbit8;
                nd++;
            end
            if (diff8 !== d0) held = 1'b0;
            tick();
            cyc++;
        end
        chk("done8_seen", {31'd0, done8}, 32'd1);
    endtask

    initial begin
        exp_tt = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};
        rst = 1'b1;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; bin1 = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_ready8", {31'd0, ready8}, 32'd1);
        chk("rst_busy8",  {31'd0, busy8},  32'd0);
        chk("rst_done8",  {31'd0, done8},  32'd0);
        chk("rst_dv8",    {31'd0, dv8},    32'd0);
        chk("rst_dbit8",  {31'd0, dbit8},  32'd0);
        chk("rst_diff8",  {24'd0, diff8},  32'd0);
        chk("rst_bout8",  {31'd0, bout8},  32'd0);
        chk("rst_ready1", {31'd0, ready1}, 32'd1);

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            a1 = i[2]; b1 = i[1]; bin1 = i[0];
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            cyc = 0;
            while (!done1 && cyc < 10) begin
                tick();
                cyc++;
            end
            chk($sformatf("w1_lat_%0d", i), cyc, 32'd1);
            chk($sformatf("w1_res_%0d", i), {30'd0, bout1, diff1}, {30'd0, exp_tt[i]});
            nd = 0;
            for (int k = 0; k < 9; k++) begin
                tick();
                if (done1) nd++;
            end
            chk($sformatf("w1_one_done_%0d", i), nd, 32'd0);
        end

        // 0x5A - 0x3C
        go8(8'h5A, 8'h3C, 1'b0);
        chk("busy_after_start", {31'd0, busy8}, 32'd1);
        chk("ready_after_start", {31'd0, ready8}, 32'd0);
        wait_done8();
        chk("lat_5a", cyc, 32'd8);
        chk("nbits_5a", nd, 32'd8);
        chk("dbits_5a", dbits, 32'h1E);
        chk("diff_5a", {24'd0, diff8}, 32'h1E);
        chk("bout_5a", {31'd0, bout8}, 32'd0);
        tick();
        chk("done_pulse_len", {31'd0, done8}, 32'd0);

        // Boundaries
        go8(8'h00, 8'h01, 1'b0);
        wait_done8();
        chk("diff_00m01", {24'd0, diff8}, 32'hFF);
        chk("bout_00m01", {31'd0, bout8}, 32'd1);
        tick();
        go8(8'h10, 8'h0F, 1'b1);
        wait_done8();
        chk("diff_10m0f", {24'd0, diff8}, 32'h00);
        chk("bout_10m0f", {31'd0, bout8}, 32'd0);
        tick();
        go8(8'hFF, 8'hFF, 1'b1);
        wait_done8();
        chk("diff_ffmff", {24'd0, diff8}, 32'hFF);
        chk("bout_ffmff", {31'd0, bout8}, 32'd1);
        tick();

        // Start during SHIFT is ignored
        go8(8'h5A, 8'h3C, 1'b0);
        tick(); tick(); tick();
        a8 = 8'h00; b8 = 8'h01; bin8 = 1'b1; start8 = 1'b1;
        chk("ign_busy", {31'd0, busy8}, 32'd1);
        chk("ign_ready", {31'd0, ready8}, 32'd0);
        tick();
        start8 = 1'b0;
        wait_done8();
        chk("ign_lat", cyc, 32'd4);
        chk("ign_diff", {24'd0, diff8}, 32'h1E);
        chk("ign_bout", {31'd0, bout8}, 32'd0);

        // Back-to-back start during DONE: second done 9 cycles after first
        go8(8'h80, 8'h01, 1'b0);
        wait_done8();
        chk("b2b_lat", cyc + 1, 32'd9);
        chk("b2b_diff", {24'd0, diff8}, 32'h7F);
        chk("b2b_bout", {31'd0, bout8}, 32'd0);
        tick();

        // Reset abort in the middle of SHIFT
        go8(8'h5A, 8'h3C, 1'b0);
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'h00);
        chk("abort_bout", {31'd0, bout8}, 32'd0);
        chk("abort_ready", {31'd0, ready8}, 32'd1);
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) nd++;
            tick();
        end
        chk("abort_no_done", nd, 32'd0);
        go8(8'h80, 8'h01, 1'b0);
        wait_done8();
        chk("post_abort_diff", {24'd0, diff8}, 32'h7F);
        chk("post_abort_bout", {31'd0, bout8}, 32'd0);
        tick();

        // Result hold across a following computation
        go8(8'h5A, 8'h3C, 1'b0);
        wait_done8();
        chk("hold_first_diff", {24'd0, diff8}, 32'h1E);
        go8(8'h00, 8'h01, 1'b0);
        chk("hold_start_diff", {24'd0, diff8}, 32'h1E);
        wait_done8();
        chk("hold_stable", {31'd0, held}, 32'd1);
        chk("hold_final_diff", {24'd0, diff8}, 32'hFF);
        chk("hold_final_bout", {31'd0, bout8}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
